// File: rtl/midi_pkg.sv
// Shared constants, FSM state types and helper functions for the MIDI I/O core.
package midi_pkg;

    localparam logic [7:0] CC_MSG = 8'hB0;
    localparam logic [7:0] PC_MSG = 8'hC0;
    localparam logic [7:0] CP_MSG = 8'hD0;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Program change and channel pressure carry one data byte; every other
    // channel message carries two.
    function automatic logic [1:0] midi_byte_count(input logic [7:0] status);
        if (status[7:4] == PC_MSG[7:4] || status[7:4] == CP_MSG[7:4]) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

    // Line level for bit position pos (0..9) of a serial frame:
    // start bit, eight data bits LSB-first, stop bit.
    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] pos);
        logic bit_v;
        case (pos)
            4'd0:    bit_v = 1'b0;
            4'd1:    bit_v = data[0];
            4'd2:    bit_v = data[1];
            4'd3:    bit_v = data[2];
            4'd4:    bit_v = data[3];
            4'd5:    bit_v = data[4];
            4'd6:    bit_v = data[5];
            4'd7:    bit_v = data[6];
            4'd8:    bit_v = data[7];
            default: bit_v = 1'b1;
        endcase
        return bit_v;
    endfunction

endpackage

// File: rtl/midi_io_core_debounce.sv
// Single-button debouncer: the output follows the synchronised input only
// after the input has disagreed with it for 2^CNT_W consecutive cycles.
module midi_io_core_debounce
    import midi_pkg::*;
#(
    parameter int CNT_W = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_i,
    output logic deb_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;

    // Count cycles of disagreement; any return to agreement restarts the count
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync_i != deb_q) begin
            if (&cnt_q) begin
                deb_d = sync_i;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter and debounced level registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/midi_io_core.sv
// MIDI front-end: button debounce/strobe, MIDI receiver with running-status
// parser, and a MIDI transmitter for up to three framed bytes.
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line held high, waiting for tx_trigger with nonzero tx_bits
//   TX_SHIFT | shifting latched command out, one bit per BAUD_DIV cycles
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synced line
//   RX_START | timing to mid start bit to confirm it is still low
//   RX_DATA  | sampling eight data bits at bit centres
//   RX_STOP  | sampling the stop bit; high hands byte to parser
module midi_io_core
    import midi_pkg::*;
#(
    parameter int BAUD_DIV     = 3200,
    parameter int DEBOUNCE_CNT = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn1,
    input  logic       btn2,
    input  logic       midi_rx,
    output logic       midi_tx,
    input  logic [1:0] midi_in_state,
    output logic [1:0] btn_index,
    output logic       save_mode,
    output logic [7:0] rx_status,
    output logic [7:0] rx_data1,
    output logic [7:0] rx_data2,
    output logic [1:0] rx_bytes,
    output logic       rx_done,
    input  logic [7:0] tx_status,
    input  logic [7:0] tx_data1,
    input  logic [7:0] tx_data2,
    input  logic [7:0] tx_bits,
    input  logic       tx_trigger,
    output logic       tx_busy
);

    localparam int                BAUD_W    = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(BAUD_DIV / 2 - 1);

    // ------------------------------------------------------------------
    // Input synchronisers and button strobe
    // ------------------------------------------------------------------
    logic [1:0] btn_meta_q, btn_sync_q;
    logic       rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0] deb;
    logic [1:0] deb_prev_q;
    logic [1:0] btn_index_q;
    logic       save_mode_q;
    logic       deb_rise;

    // Two-flop synchronisers; the MIDI line idles high so it resets high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q <= 2'b00;
            btn_sync_q <= 2'b00;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            btn_meta_q <= {btn2, btn1};
            btn_sync_q <= btn_meta_q;
            rx_meta_q  <= midi_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
        end
    end

    midi_io_core_debounce #(.CNT_W(DEBOUNCE_CNT)) u_deb1 (
        .clk    (clk),
        .rst    (rst),
        .sync_i (btn_sync_q[0]),
        .deb_o  (deb[0])
    );

    midi_io_core_debounce #(.CNT_W(DEBOUNCE_CNT)) u_deb2 (
        .clk    (clk),
        .rst    (rst),
        .sync_i (btn_sync_q[1]),
        .deb_o  (deb[1])
    );

    assign deb_rise = |(deb & ~deb_prev_q);

    // One-cycle strobe reporting every debounced button that is down when any rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_prev_q  <= 2'b00;
            btn_index_q <= 2'd0;
            save_mode_q <= 1'b0;
        end else begin
            deb_prev_q  <= deb;
            btn_index_q <= deb_rise ? deb : 2'd0;
            save_mode_q <= deb_rise && (midi_in_state == 2'd1);
        end
    end

    assign btn_index = btn_index_q;
    assign save_mode = save_mode_q;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [23:0]       tx_buf_q, tx_buf_d;
    logic [7:0]        tx_left_q, tx_left_d;
    logic [1:0]        tx_sel_q, tx_sel_d;
    logic [3:0]        tx_pos_q, tx_pos_d;
    logic [BAUD_W-1:0] tx_baud_q, tx_baud_d;
    logic              midi_tx_q, midi_tx_d;
    logic [7:0]        tx_byte;

    // TX next state; the line level is derived from the next position so it is registered
    always_comb begin
        tx_state_d = tx_state_q;
        tx_buf_d   = tx_buf_q;
        tx_left_d  = tx_left_q;
        tx_sel_d   = tx_sel_q;
        tx_pos_d   = tx_pos_q;
        tx_baud_d  = tx_baud_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_trigger && tx_bits != 8'd0) begin
                    tx_buf_d   = {tx_data2, tx_data1, tx_status};
                    tx_left_d  = tx_bits;
                    tx_sel_d   = 2'd0;
                    tx_pos_d   = 4'd0;
                    tx_baud_d  = '0;
                    tx_state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d = '0;
                    tx_left_d = tx_left_q - 8'd1;
                    if (tx_left_q == 8'd1) begin
                        tx_state_d = TX_IDLE;
                    end else if (tx_pos_q == 4'd9) begin
                        tx_pos_d = 4'd0;
                        // Bit counts beyond three frames just hold the line high
                        if (tx_sel_q != 2'd3) begin
                            tx_sel_d = tx_sel_q + 2'd1;
                        end
                    end else begin
                        tx_pos_d = tx_pos_q + 4'd1;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + BAUD_W'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        case (tx_sel_d)
            2'd0:    tx_byte = tx_buf_d[7:0];
            2'd1:    tx_byte = tx_buf_d[15:8];
            2'd2:    tx_byte = tx_buf_d[23:16];
            default: tx_byte = 8'hFF;
        endcase

        midi_tx_d = 1'b1;
        if (tx_state_d == TX_SHIFT && tx_sel_d != 2'd3) begin
            midi_tx_d = frame_bit(tx_byte, tx_pos_d);
        end
    end

    // TX state registers; reset drives the line high at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_buf_q   <= '0;
            tx_left_q  <= '0;
            tx_sel_q   <= '0;
            tx_pos_q   <= '0;
            tx_baud_q  <= '0;
            midi_tx_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_buf_q   <= tx_buf_d;
            tx_left_q  <= tx_left_d;
            tx_sel_q   <= tx_sel_d;
            tx_pos_q   <= tx_pos_d;
            tx_baud_q  <= tx_baud_d;
            midi_tx_q  <= midi_tx_d;
        end
    end

    assign midi_tx = midi_tx_q;
    assign tx_busy = (tx_state_q == TX_SHIFT);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_e         rx_state_q, rx_state_d;
    logic [BAUD_W-1:0] rx_baud_q, rx_baud_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_byte_ok;
    logic              rx_frame_err;

    // RX bit timing: confirm start at half a bit, then sample every full bit
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_baud_d    = rx_baud_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_byte_ok   = 1'b0;
        rx_frame_err = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_baud_d  = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_baud_q == HALF_LAST) begin
                    rx_baud_d = '0;
                    rx_bit_d  = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + BAUD_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + BAUD_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d    = '0;
                    rx_state_d   = RX_IDLE;
                    rx_byte_ok   = rx_sync_q;
                    rx_frame_err = !rx_sync_q;
                end else begin
                    rx_baud_d = rx_baud_q + BAUD_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    logic [7:0] run_status_q;
    logic [7:0] run_data1_q;
    logic       have_data1_q;
    logic [7:0] rx_status_q, rx_data1_q, rx_data2_q;
    logic [1:0] rx_bytes_q;
    logic       rx_done_q;

    // Command parser with running status; system bytes never touch its state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_status_q <= '0;
            run_data1_q  <= '0;
            have_data1_q <= 1'b0;
            rx_status_q  <= '0;
            rx_data1_q   <= '0;
            rx_data2_q   <= '0;
            rx_bytes_q   <= '0;
            rx_done_q    <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            if (rx_frame_err) begin
                run_status_q <= '0;
                have_data1_q <= 1'b0;
            end else if (rx_byte_ok && rx_shift_q[7:4] != 4'hF) begin
                if (rx_shift_q[7]) begin
                    run_status_q <= rx_shift_q;
                    have_data1_q <= 1'b0;
                end else if (run_status_q[7]) begin
                    if (!have_data1_q && midi_byte_count(run_status_q) == 2'd2) begin
                        rx_status_q <= run_status_q;
                        rx_data1_q  <= rx_shift_q;
                        rx_data2_q  <= 8'h00;
                        rx_bytes_q  <= 2'd2;
                        rx_done_q   <= 1'b1;
                    end else if (!have_data1_q) begin
                        run_data1_q  <= rx_shift_q;
                        have_data1_q <= 1'b1;
                    end else begin
                        rx_status_q  <= run_status_q;
                        rx_data1_q   <= run_data1_q;
                        rx_data2_q   <= rx_shift_q;
                        rx_bytes_q   <= 2'd3;
                        rx_done_q    <= 1'b1;
                        have_data1_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign rx_status = rx_status_q;
    assign rx_data1  = rx_data1_q;
    assign rx_data2  = rx_data2_q;
    assign rx_bytes  = rx_bytes_q;
    assign rx_done   = rx_done_q;

endmodule

// File: tb/tb_midi_io_core.sv
// Bench for midi_io_core with short baud and debounce settings: random TX
// commands against a frame model, random RX byte streams against a MIDI
// parser model, debounce strobes and reset behaviour.
module tb_midi_io_core;
    import midi_pkg::*;

    localparam int BD = 32;
    localparam int DB = 4;

    logic       clk;
    logic       rst;
    logic       btn1, btn2, midi_rx;
    logic       midi_tx;
    logic [1:0] midi_in_state;
    logic [1:0] btn_index;
    logic       save_mode;
    logic [7:0] rx_status, rx_data1, rx_data2;
    logic [1:0] rx_bytes;
    logic       rx_done;
    logic [7:0] tx_status, tx_data1, tx_data2, tx_bits;
    logic       tx_trigger;
    logic       tx_busy;

    midi_io_core #(.BAUD_DIV(BD), .DEBOUNCE_CNT(DB)) dut (
        .clk           (clk),
        .rst           (rst),
        .btn1          (btn1),
        .btn2          (btn2),
        .midi_rx       (midi_rx),
        .midi_tx       (midi_tx),
        .midi_in_state (midi_in_state),
        .btn_index     (btn_index),
        .save_mode     (save_mode),
        .rx_status     (rx_status),
        .rx_data1      (rx_data1),
        .rx_data2      (rx_data2),
        .rx_bytes      (rx_bytes),
        .rx_done       (rx_done),
        .tx_status     (tx_status),
        .tx_data1      (tx_data1),
        .tx_data2      (tx_data2),
        .tx_bits       (tx_bits),
        .tx_trigger    (tx_trigger),
        .tx_busy       (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitors (sole writers of the logs and counters below)
    int          cyc = 0;
    int          busy_total = 0;
    logic [31:0] rx_log[$];
    int          rx_cyc[$];
    logic [2:0]  stb_log[$];
    int          stb_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (tx_busy) busy_total++;
        if (rx_done) begin
            rx_log.push_back({6'd0, rx_bytes, rx_status, rx_data1, rx_data2});
            rx_cyc.push_back(cyc);
        end
        if (btn_index != 2'd0 || save_mode) begin
            stb_log.push_back({save_mode, btn_index});
            stb_cyc.push_back(cyc);
        end
    end

    // Expected line bits for a command: 10-bit frames, truncated at n bits
    function automatic logic [31:0] tx_expect(input logic [7:0] s, input logic [7:0] d1,
                                               input logic [7:0] d2, input int n);
        logic [7:0]  cmd[3];
        logic [31:0] v;
        cmd[0] = s; cmd[1] = d1; cmd[2] = d2;
        v = '0;
        for (int k = 0; k < n; k++) begin
            int         p;
            logic [7:0] cb;
            p  = k % 10;
            cb = cmd[k / 10];
            if (p == 0)      v[k] = 1'b0;
            else if (p == 9) v[k] = 1'b1;
            else             v[k] = cb[p - 1];
        end
        return v;
    endfunction

    task automatic send_tx(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2, input int n);
        logic [31:0] seen;
        int          b0;
        seen = '0;
        @(negedge clk);
        tx_status = s; tx_data1 = d1; tx_data2 = d2; tx_bits = 8'(n); tx_trigger = 1'b1;
        @(posedge clk); #1;
        tx_trigger = 1'b0;
        b0 = busy_total;
        tx_status = 8'($urandom); tx_data1 = 8'($urandom); tx_data2 = 8'($urandom);
        for (int k = 0; k < n; k++) begin
            repeat ((k == 0) ? BD / 2 : BD) @(posedge clk);
            #1;
            seen[k] = midi_tx;
        end
        check_val($sformatf("tx_line %02h %02h %02h n=%0d", s, d1, d2, n), seen, tx_expect(s, d1, d2, n));
        repeat (BD) @(posedge clk);
        #1;
        check_val($sformatf("tx_busy_len n=%0d", n), 32'(busy_total - b0), 32'(n * BD));
        check_val("tx_idle_after", 32'(midi_tx), 32'd1);
    endtask

    // Reference MIDI parser, applied to every byte put on the line
    logic [7:0]  m_status = 8'h00;
    logic [7:0]  m_d1 = 8'h00;
    int          m_have = 0;
    logic [31:0] rx_exp[$];
    int          rx_seen = 0;

    task automatic model_rx(input logic [7:0] b, input logic ok);
        int need;
        if (!ok) begin
            m_status = 8'h00;
            m_have   = 0;
        end else if (b >= 8'hF0) begin
            m_have = m_have;
        end else if (b >= 8'h80) begin
            m_status = b;
            m_have   = 0;
        end else if (m_status != 8'h00) begin
            need = (m_status[7:4] == 4'hC || m_status[7:4] == 4'hD) ? 2 : 3;
            if (m_have == 0 && need == 2) begin
                rx_exp.push_back({6'd0, 2'd2, m_status, b, 8'h00});
            end else if (m_have == 0) begin
                m_d1   = b;
                m_have = 1;
            end else begin
                rx_exp.push_back({6'd0, 2'd3, m_status, m_d1, b});
                m_have = 0;
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic ok);
        midi_rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            midi_rx = b[i];
            repeat (BD) @(negedge clk);
        end
        midi_rx = ok;
        repeat (BD) @(negedge clk);
        midi_rx = 1'b1;
        repeat (BD) @(negedge clk);
        model_rx(b, ok);
    endtask

    task automatic rx_compare(input string tag);
        int got_n;
        repeat (2 * BD) @(negedge clk);
        got_n = rx_log.size() - rx_seen;
        check_val({tag, " count"}, 32'(got_n), 32'(rx_exp.size()));
        for (int i = 0; i < rx_exp.size(); i++) begin
            if (rx_seen + i < rx_log.size()) begin
                check_val($sformatf("%s cmd%0d", tag, i), rx_log[rx_seen + i], rx_exp[i]);
            end
        end
        rx_seen = rx_log.size();
        rx_exp.delete();
    endtask

    initial begin
        int          t0;
        int          s0;
        int          n;
        logic [7:0]  b;
        logic        ok;

        rst = 1'b1;
        btn1 = 1'b0; btn2 = 1'b0; midi_rx = 1'b1;
        midi_in_state = 2'd0;
        tx_status = 8'h00; tx_data1 = 8'h00; tx_data2 = 8'h00; tx_bits = 8'd0; tx_trigger = 1'b0;
        repeat (3) @(negedge clk);

        check_val("rst midi_tx", 32'(midi_tx), 32'd1);
        check_val("rst tx_busy", 32'(tx_busy), 32'd0);
        check_val("rst btn_index", 32'(btn_index), 32'd0);
        check_val("rst save_mode", 32'(save_mode), 32'd0);
        check_val("rst rx_done", 32'(rx_done), 32'd0);
        check_val("rst rx_outs", {6'd0, rx_bytes, rx_status, rx_data1, rx_data2}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_val("idle midi_tx", 32'(midi_tx), 32'd1);

        // TX: directed 3-byte control change, then random commands and bit counts
        send_tx(CC_MSG, 8'h2E, 8'h7F, 30);
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0:       n = 10;
                1:       n = 20;
                2:       n = 30;
                default: n = $urandom_range(1, 29);
            endcase
            send_tx(8'($urandom_range(8'h80, 8'hEF)), 8'($urandom_range(0, 127)),
                    8'($urandom_range(0, 127)), n);
        end

        // TX: zero bit count must not start a frame
        @(negedge clk);
        tx_bits = 8'd0; tx_trigger = 1'b1;
        repeat (5) @(negedge clk);
        tx_trigger = 1'b0;
        check_val("tx zero bits busy", 32'(tx_busy), 32'd0);
        check_val("tx zero bits line", 32'(midi_tx), 32'd1);

        // RX: two-byte program change, with latency of the final byte
        send_rx(PC_MSG, 1'b1);
        t0 = cyc;
        send_rx(8'h42, 1'b1);
        rx_compare("rx pc");
        check_val("rx pc value", rx_log[rx_log.size() - 1], {6'd0, 2'd2, 8'hC0, 8'h42, 8'h00});
        n = rx_cyc[rx_cyc.size() - 1] - t0;
        check_val($sformatf("rx latency %0d in window", n), 32'(n >= 9 * BD + BD / 2 - 6 && n <= 9 * BD + BD / 2 + 10), 32'd1);

        // RX: full command followed by running status
        send_rx(CC_MSG, 1'b1); send_rx(8'h2F, 1'b1); send_rx(8'h7F, 1'b1);
        send_rx(8'h30, 1'b1); send_rx(8'h00, 1'b1);
        rx_compare("rx running");
        check_val("rx running value", rx_log[rx_log.size() - 1], {6'd0, 2'd3, 8'hB0, 8'h30, 8'h00});

        // RX: realtime byte inside a command, then a framing error
        send_rx(CC_MSG, 1'b1); send_rx(8'hF8, 1'b1); send_rx(8'h2E, 1'b1); send_rx(8'h7F, 1'b1);
        rx_compare("rx realtime");
        check_val("rx realtime value", rx_log[rx_log.size() - 1], {6'd0, 2'd3, 8'hB0, 8'h2E, 8'h7F});
        send_rx(8'h45, 1'b0);
        send_rx(8'h11, 1'b1);
        rx_compare("rx framing");

        // RX: random byte streams
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 12; i++) begin
                ok = 1'b1;
                case ($urandom_range(0, 9))
                    0, 1:    b = 8'($urandom_range(8'h80, 8'hEF));
                    2:       b = 8'($urandom_range(8'hF0, 8'hFF));
                    3: begin
                        b  = 8'($urandom);
                        ok = ($urandom_range(0, 1) == 0);
                    end
                    default: b = 8'($urandom_range(0, 127));
                endcase
                send_rx(b, ok);
            end
            rx_compare($sformatf("rx random%0d", s));
        end

        // Debounce: bouncing btn1 yields one strobe with save_mode
        midi_in_state = 2'd1;
        s0 = stb_log.size();
        for (int i = 0; i < 6; i++) begin
            btn1 = 1'b1;
            repeat ($urandom_range(1, 8)) @(negedge clk);
            btn1 = 1'b0;
            repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        btn1 = 1'b1;
        repeat (40) @(negedge clk);
        check_val("btn1 strobe count", 32'(stb_log.size() - s0), 32'd1);
        if (stb_log.size() > s0) check_val("btn1 strobe", 32'(stb_log[s0]), {29'd0, 1'b1, 2'd1});

        // Second button while first held reports both, save_mode off when assigned
        midi_in_state = 2'd2;
        s0 = stb_log.size();
        t0 = cyc;
        btn2 = 1'b1;
        repeat (40) @(negedge clk);
        check_val("btn2 strobe count", 32'(stb_log.size() - s0), 32'd1);
        if (stb_log.size() > s0) begin
            check_val("btn both strobe", 32'(stb_log[s0]), {29'd0, 1'b0, 2'd3});
            n = stb_cyc[s0] - t0;
            check_val($sformatf("debounce latency %0d in window", n), 32'(n >= (1 << DB) + 1 && n <= (1 << DB) + 5), 32'd1);
        end

        // Releases produce no strobe
        s0 = stb_log.size();
        btn1 = 1'b0; btn2 = 1'b0;
        repeat (40) @(negedge clk);
        check_val("release no strobe", 32'(stb_log.size() - s0), 32'd0);

        // Reset in the middle of a frame
        @(negedge clk);
        tx_status = CC_MSG; tx_data1 = 8'h55; tx_data2 = 8'h2A; tx_bits = 8'd30; tx_trigger = 1'b1;
        @(posedge clk); #1;
        tx_trigger = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check_val("tx line low before rst", 32'(midi_tx), 32'd0);
        check_val("tx busy before rst", 32'(tx_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("rst mid midi_tx", 32'(midi_tx), 32'd1);
        check_val("rst mid tx_busy", 32'(tx_busy), 32'd0);
        check_val("rst mid rx_outs", {6'd0, rx_bytes, rx_status, rx_data1, rx_data2}, 32'd0);
        m_status = 8'h00;
        m_have   = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_tx(8'($urandom_range(8'h80, 8'hEF)), 8'($urandom_range(0, 127)), 8'($urandom_range(0, 127)), 30);
        check_val("no rx after rst", 32'(rx_log.size() - rx_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
